// File: rtl/dwrr_credit_sched_if.sv
// Signal bundle for the DWRR credit scheduler: config writes, replenish/grant,
// consume/underflow and credit query.
interface dwrr_credit_sched_if #(
  parameter int unsigned DEPTH_W   = 5,
  parameter int unsigned FLOW_W    = 3,
  parameter int unsigned CREDIT_W  = 8,
  parameter int unsigned QUANTUM_W = 4
) ();
  logic                 cfg_wr_en;
  logic [DEPTH_W-1:0]   cfg_wr_addr;
  logic [FLOW_W-1:0]    cfg_wr_flow;
  logic                 q_wr_en;
  logic [FLOW_W-1:0]    q_wr_flow;
  logic [QUANTUM_W-1:0] q_wr_val;
  logic                 replenish;
  logic                 grant_valid;
  logic [FLOW_W-1:0]    grant_flow;
  logic                 consume_valid;
  logic [FLOW_W-1:0]    consume_flow;
  logic [CREDIT_W-1:0]  consume_amt;
  logic [FLOW_W-1:0]    query_flow;
  logic [CREDIT_W-1:0]  query_credit;
  logic                 underflow;
  logic                 init_done;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_flow, q_wr_en, q_wr_flow, q_wr_val, replenish,
           consume_valid, consume_flow, consume_amt, query_flow,
    input  grant_valid, grant_flow, query_credit, underflow, init_done
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_flow, q_wr_en, q_wr_flow, q_wr_val, replenish,
           consume_valid, consume_flow, consume_amt, query_flow,
    output grant_valid, grant_flow, query_credit, underflow, init_done
  );
endinterface

// File: rtl/dwrr_credit_sched.sv
// Deficit-weighted round-robin credit scheduler: an order table is walked one step per
// replenish, each step grants its flow a quantum of credit; consumers debit credit.
module dwrr_credit_sched #(
  parameter int unsigned DEPTH_W   = 5,
  parameter int unsigned FLOW_W    = 3,
  parameter int unsigned CREDIT_W  = 8,
  parameter int unsigned QUANTUM_W = 4
) (
  input logic                  clk,
  input logic                  rstn,
  dwrr_credit_sched_if.slave   bus
);

  localparam int Entries = 2 ** DEPTH_W;
  localparam int Flows   = 2 ** FLOW_W;

  if (FLOW_W > DEPTH_W) begin : g_bad_flow_w
    $error("FLOW_W must not exceed DEPTH_W");
  end
  if (QUANTUM_W > CREDIT_W) begin : g_bad_quantum_w
    $error("QUANTUM_W must not exceed CREDIT_W");
  end

  typedef enum logic {StInit, StRun} state_e;

  state_e               state_q, state_d;
  logic [DEPTH_W-1:0]   init_ptr_q;
  logic [DEPTH_W-1:0]   rd_ptr_q;
  logic [FLOW_W-1:0]    order_tbl [Entries];
  logic                 rd_valid_q;
  logic [FLOW_W-1:0]    rd_flow_q;
  logic                 grant_valid_q;
  logic [FLOW_W-1:0]    grant_flow_q;
  logic [CREDIT_W-1:0]  credit_q [Flows];
  logic [CREDIT_W-1:0]  credit_d [Flows];
  logic [QUANTUM_W-1:0] quantum_q [Flows];
  logic                 underflow_q, underflow_d;
  logic [CREDIT_W-1:0]  query_credit_q;
  logic                 run;

  assign run = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (&init_ptr_q) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Table is not reset: INIT rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      order_tbl[init_ptr_q] <= init_ptr_q[FLOW_W-1:0];
    end else if (bus.cfg_wr_en) begin
      order_tbl[bus.cfg_wr_addr] <= bus.cfg_wr_flow;
    end
  end

  // Grant credit is applied before the debit so a same-flow collision nets out correctly.
  always_comb begin : p_credit
    logic [CREDIT_W:0] acc;
    underflow_d = 1'b0;
    acc         = '0;
    for (int f = 0; f < Flows; f++) begin
      acc = {1'b0, credit_q[f]};
      if (grant_valid_q && grant_flow_q == FLOW_W'(f)) begin
        acc = acc + (CREDIT_W + 1)'(quantum_q[f]);
        if (acc[CREDIT_W]) acc = {1'b0, {CREDIT_W{1'b1}}};
      end
      if (run && bus.consume_valid && bus.consume_flow == FLOW_W'(f)) begin
        if (acc < {1'b0, bus.consume_amt}) begin
          acc         = '0;
          underflow_d = 1'b1;
        end else begin
          acc = acc - {1'b0, bus.consume_amt};
        end
      end
      credit_d[f] = acc[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= StInit;
      init_ptr_q     <= '0;
      rd_ptr_q       <= '0;
      rd_valid_q     <= 1'b0;
      rd_flow_q      <= '0;
      grant_valid_q  <= 1'b0;
      grant_flow_q   <= '0;
      underflow_q    <= 1'b0;
      query_credit_q <= '0;
      for (int f = 0; f < Flows; f++) begin
        credit_q[f]  <= '0;
        quantum_q[f] <= QUANTUM_W'(1);
      end
    end else begin
      state_q <= state_d;
      if (state_q == StInit) init_ptr_q <= init_ptr_q + 1'b1;
      rd_valid_q <= run && bus.replenish;
      if (run && bus.replenish) begin
        rd_flow_q <= order_tbl[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      grant_valid_q  <= rd_valid_q;
      grant_flow_q   <= rd_flow_q;
      credit_q       <= credit_d;
      underflow_q    <= underflow_d;
      query_credit_q <= credit_d[bus.query_flow];
      if (run && bus.q_wr_en) quantum_q[bus.q_wr_flow] <= bus.q_wr_val;
    end
  end

  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_flow   = grant_flow_q;
  assign bus.query_credit = query_credit_q;
  assign bus.underflow    = underflow_q;
  assign bus.init_done    = run;

endmodule

// File: tb/tb_dwrr_credit_sched.sv
// Directed bench for dwrr_credit_sched: default instance plus a CREDIT_W=4 instance
// for the saturation and same-cycle grant/consume cases.
module tb_dwrr_credit_sched;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_fail;

  dwrr_credit_sched_if #(.DEPTH_W(5), .FLOW_W(3), .CREDIT_W(8), .QUANTUM_W(4)) bus ();
  dwrr_credit_sched_if #(.DEPTH_W(5), .FLOW_W(3), .CREDIT_W(4), .QUANTUM_W(4)) bus4 ();

  dwrr_credit_sched #(.DEPTH_W(5), .FLOW_W(3), .CREDIT_W(8), .QUANTUM_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  dwrr_credit_sched #(.DEPTH_W(5), .FLOW_W(3), .CREDIT_W(4), .QUANTUM_W(4)) dut4 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One reset edge, then 32 INIT cycles; returns in the first RUN cycle.
  task automatic reset_and_init();
    rstn = 1'b0;
    tick();
    check("rst_init_done", 32'(bus.init_done), 0);
    check("rst_grant_valid", 32'(bus.grant_valid), 0);
    check("rst_underflow", 32'(bus.underflow), 0);
    check("rst_grant_flow", 32'(bus.grant_flow), 0);
    check("rst_query_credit", 32'(bus.query_credit), 0);
    rstn = 1'b1;
    for (int c = 1; c < 32; c++) begin
      tick();
      check("init_no_grant", 32'(bus.grant_valid), 0);
    end
    check("init_done_c31", 32'(bus.init_done), 0);
    tick();
    check("init_done_c32", 32'(bus.init_done), 1);
    check("init_done4_c32", 32'(bus4.init_done), 1);
  endtask

  logic [2:0] exp_g [3] = '{3'd0, 3'd5, 3'd2};

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    {bus.cfg_wr_en, bus.cfg_wr_addr, bus.cfg_wr_flow} = '0;
    {bus.q_wr_en, bus.q_wr_flow, bus.q_wr_val} = '0;
    {bus.replenish, bus.consume_valid, bus.consume_flow, bus.consume_amt} = '0;
    bus.query_flow = '0;
    {bus4.cfg_wr_en, bus4.cfg_wr_addr, bus4.cfg_wr_flow} = '0;
    {bus4.q_wr_en, bus4.q_wr_flow, bus4.q_wr_val} = '0;
    {bus4.replenish, bus4.consume_valid, bus4.consume_flow, bus4.consume_amt} = '0;
    bus4.query_flow = '0;
    tick();

    // Traffic during INIT must be ignored.
    bus.replenish = 1'b1;
    bus.q_wr_en = 1'b1;  bus.q_wr_flow = 3'd0;  bus.q_wr_val = 4'd9;
    bus.consume_valid = 1'b1;  bus.consume_flow = 3'd0;  bus.consume_amt = 8'd1;
    bus.cfg_wr_en = 1'b1;  bus.cfg_wr_addr = 5'd0;  bus.cfg_wr_flow = 3'd7;
    reset_and_init();
    bus.replenish = 1'b0;  bus.q_wr_en = 1'b0;  bus.consume_valid = 1'b0;  bus.cfg_wr_en = 1'b0;

    // 32 back-to-back replenishes: grants 0..7 x4, two cycles after each request.
    for (int k = 0; k < 34; k++) begin
      bus.replenish = (k < 32);
      check("full_grant_valid", 32'(bus.grant_valid), 32'(k >= 2));
      if (k >= 2) check("full_grant_flow", 32'(bus.grant_flow), (k - 2) % 8);
      tick();
    end
    bus.query_flow = 3'd0;
    tick();
    check("full_credit_f0", 32'(bus.query_credit), 4);
    bus.query_flow = 3'd7;
    tick();
    check("full_credit_f7", 32'(bus.query_credit), 4);

    // Fresh start: table entry 1 -> flow 5, quantum[5] = 3.
    reset_and_init();
    bus.cfg_wr_en = 1'b1;  bus.cfg_wr_addr = 5'd1;  bus.cfg_wr_flow = 3'd5;
    bus.q_wr_en = 1'b1;  bus.q_wr_flow = 3'd5;  bus.q_wr_val = 4'd3;
    tick();
    bus.cfg_wr_en = 1'b0;  bus.q_wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.replenish = (k < 3);
      check("cfg_grant_valid", 32'(bus.grant_valid), 32'(k >= 2));
      if (k >= 2) check("cfg_grant_flow", 32'(bus.grant_flow), 32'(exp_g[k-2]));
      tick();
    end
    bus.query_flow = 3'd5;
    tick();
    check("cfg_credit_f5", 32'(bus.query_credit), 3);
    bus.query_flow = 3'd2;
    tick();
    check("cfg_credit_f2", 32'(bus.query_credit), 1);

    // Write to the entry being read returns old data; a prior write is seen.
    bus.replenish = 1'b1;
    bus.cfg_wr_en = 1'b1;  bus.cfg_wr_addr = 5'd3;  bus.cfg_wr_flow = 3'd6;
    tick();
    bus.replenish = 1'b0;  bus.cfg_wr_addr = 5'd4;
    tick();
    bus.cfg_wr_en = 1'b0;
    check("rw_old_valid", 32'(bus.grant_valid), 1);
    check("rw_old_flow", 32'(bus.grant_flow), 3);
    bus.replenish = 1'b1;
    tick();
    bus.replenish = 1'b0;
    check("rw_gap_valid", 32'(bus.grant_valid), 0);
    tick();
    check("rw_new_valid", 32'(bus.grant_valid), 1);
    check("rw_new_flow", 32'(bus.grant_flow), 6);
    tick();

    // Build credit[2] = 1 + 3 = 4, then over-debit by 6.
    bus.cfg_wr_en = 1'b1;  bus.cfg_wr_addr = 5'd5;  bus.cfg_wr_flow = 3'd2;
    bus.q_wr_en = 1'b1;  bus.q_wr_flow = 3'd2;  bus.q_wr_val = 4'd3;
    tick();
    bus.cfg_wr_en = 1'b0;  bus.q_wr_en = 1'b0;  bus.replenish = 1'b1;
    tick();
    bus.replenish = 1'b0;
    tick();
    check("uf_grant_flow", 32'(bus.grant_flow), 2);
    bus.query_flow = 3'd2;
    tick();
    check("uf_credit_pre", 32'(bus.query_credit), 4);
    bus.consume_valid = 1'b1;  bus.consume_flow = 3'd2;  bus.consume_amt = 8'd6;
    tick();
    bus.consume_valid = 1'b0;
    check("uf_pulse", 32'(bus.underflow), 1);
    check("uf_credit_clamp", 32'(bus.query_credit), 0);
    tick();
    check("uf_pulse_once", 32'(bus.underflow), 0);

    // CREDIT_W=4 instance: saturation at 15.
    bus4.q_wr_en = 1'b1;  bus4.q_wr_flow = 3'd0;  bus4.q_wr_val = 4'd15;
    bus4.cfg_wr_en = 1'b1;  bus4.cfg_wr_addr = 5'd1;  bus4.cfg_wr_flow = 3'd0;
    tick();
    bus4.q_wr_en = 1'b0;  bus4.cfg_wr_en = 1'b0;  bus4.replenish = 1'b1;
    tick();
    tick();
    bus4.replenish = 1'b0;
    check("sat_g1_flow", 32'(bus4.grant_flow), 0);
    tick();
    check("sat_g2_valid", 32'(bus4.grant_valid), 1);
    check("sat_g2_flow", 32'(bus4.grant_flow), 0);
    check("sat_credit_first", 32'(bus4.query_credit), 15);
    tick();
    check("sat_credit_second", 32'(bus4.query_credit), 15);

    // Entries 3,4 -> flow 2; three grants to flow 2, the last colliding with a debit of 5.
    bus4.cfg_wr_en = 1'b1;  bus4.cfg_wr_addr = 5'd3;  bus4.cfg_wr_flow = 3'd2;
    tick();
    bus4.cfg_wr_addr = 5'd4;
    tick();
    bus4.cfg_wr_en = 1'b0;  bus4.replenish = 1'b1;
    tick();
    tick();
    check("col_g1_flow", 32'(bus4.grant_flow), 2);
    tick();
    bus4.replenish = 1'b0;
    check("col_g2_flow", 32'(bus4.grant_flow), 2);
    bus4.consume_valid = 1'b1;  bus4.consume_flow = 3'd0;  bus4.consume_amt = 4'd4;
    bus4.query_flow = 3'd2;
    tick();
    check("col_g3_valid", 32'(bus4.grant_valid), 1);
    check("col_credit_pre", 32'(bus4.query_credit), 2);
    bus4.consume_flow = 3'd2;  bus4.consume_amt = 4'd5;
    tick();
    bus4.consume_valid = 1'b0;  bus4.query_flow = 3'd0;
    check("col_underflow", 32'(bus4.underflow), 1);
    check("col_credit_clamp", 32'(bus4.query_credit), 0);
    tick();
    check("col_underflow_once", 32'(bus4.underflow), 0);
    check("indep_credit_f0", 32'(bus4.query_credit), 11);

    // Reset mid-stream with grants in flight; credit[5] was 3 before.
    bus.query_flow = 3'd5;
    bus.replenish = 1'b1;
    tick();
    reset_and_init();
    bus.replenish = 1'b0;
    check("mid_rst_credit_f5", 32'(bus.query_credit), 0);
    tick();
    check("mid_rst_no_grant", 32'(bus.grant_valid), 0);
    tick();
    check("mid_rst_no_grant2", 32'(bus.grant_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dwrr_credit_sched.md
DWRR_CREDIT_SCHED -- requirements
Module: dwrr_credit_sched

Interface
REQ-001 SHALL have parameter DEPTH_W, default 5: order table holds 2**DEPTH_W entries.
REQ-002 SHALL have parameter FLOW_W, default 3: 2**FLOW_W flows; elaboration SHALL fail if FLOW_W > DEPTH_W.
REQ-003 SHALL have parameter CREDIT_W, default 8: per-flow credit counter width.
REQ-004 SHALL have parameter QUANTUM_W, default 4: per-flow quantum width; elaboration SHALL fail if QUANTUM_W > CREDIT_W.
REQ-005 SHALL have ports clk, rstn, as follows:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- cfg_wr_en  in  1  overwrite one order-table entry
- cfg_wr_addr  in  DEPTH_W  order-table entry index
- cfg_wr_flow  in  FLOW_W  flow written to that entry
- q_wr_en  in  1  write one flow's quantum
- q_wr_flow  in  FLOW_W  flow whose quantum is written
- q_wr_val  in  QUANTUM_W  quantum value
- replenish  in  1  advance one table step (end of packet)
- grant_valid  out  1  one-cycle pulse; grant_flow has just been credited
- grant_flow  out  FLOW_W  flow credited
- consume_valid  in  1  debit credits from one flow
- consume_flow  in  FLOW_W  flow debited
- consume_amt  in  CREDIT_W  amount debited
- query_flow  in  FLOW_W  flow whose credit is read back
- query_credit  out  CREDIT_W  credit of query_flow, registered
- underflow  out  1  one-cycle pulse; a debit was clamped at zero
- init_done  out  1  order table initialised; block accepts traffic

Function
REQ-006 SHALL run a two-state FSM, INIT -> RUN; INIT is entered from reset.
REQ-007 In INIT, SHALL write table entry i = i[FLOW_W-1:0] for i = 0..2**DEPTH_W-1, one entry per cycle, in ascending order.
REQ-008 SHALL enter RUN and raise init_done on the edge after the last INIT write, so init_done is high from cycle 2**DEPTH_W after reset release.
REQ-009 SHALL ignore cfg_wr_en, q_wr_en, replenish and consume_valid while init_done=0.
REQ-010 In RUN, SHALL accept replenish every cycle with no backpressure and read the entry at rd_ptr.
REQ-011 rd_ptr SHALL increment by 1 on each accepted replenish and wrap from 2**DEPTH_W-1 to 0.
REQ-012 SHALL assert grant_valid, with grant_flow = table[rd_ptr], exactly 2 cycles after the accepting edge.
REQ-013 SHALL be fully pipelined: N consecutive replenish cycles SHALL give N consecutive grant pulses.
REQ-014 On a cfg write to the entry read in the same cycle, the read SHALL return the old data; the new data SHALL apply from the next read.
REQ-015 In the grant cycle, SHALL update credit[grant_flow] += quantum[grant_flow], saturating at 2**CREDIT_W-1.
REQ-016 On consume_valid, SHALL update credit[consume_flow] -= consume_amt.
REQ-017 If a debit would go below 0, SHALL clamp the credit to 0 and pulse underflow the next cycle.
REQ-018 If grant and consume target the same flow in the same cycle, the result SHALL be sat(credit + quantum) - amt, clamped at 0.
REQ-019 If grant and consume target different flows in the same cycle, both updates SHALL apply independently.
REQ-020 query_credit SHALL show credit[query_flow] as of the previous edge (1-cycle latency, includes updates committed on that edge).
REQ-021 A quantum write SHALL take effect for grants issued from the next cycle on; quantum 0 SHALL still produce a grant, with no credit added.

Reset
REQ-022 With rstn=0 on an edge, SHALL clear: init_done, grant_valid, underflow, grant_flow=0, query_credit=0, rd_ptr=0, all credits=0, all quanta=1, pipeline flushed.
REQ-023 Reset during INIT or RUN SHALL discard in-flight grants and restart INIT at entry 0.

Verification
REQ-024 Release reset, defaults -> init_done rises at cycle 32; replenish 32x -> grant_flow 0..7 repeated 4 times, each 2 cycles after its request.
REQ-025 cfg_wr addr 1 -> flow 5, quantum[5]=3, then 3 replenishes -> grants 0,5,2; query_flow=5 -> query_credit=3.
REQ-026 credit[2]=4, consume flow 2 amt 6 -> credit[2]=0, underflow pulses once.
REQ-027 CREDIT_W=4, quantum 15 on flow 0, two grants to flow 0 -> credit[0] saturates at 15; same-cycle grant+consume amt 5 on a flow with credit 2, quantum 1 -> credit 0, underflow pulses.
REQ-028 Assert rstn mid-stream with 2 grants in flight -> no grant_valid pulse, all credits 0, INIT restarts and init_done rises 32 cycles after release.
